// File: rtl/merlin_pfu_pkg.sv
// Shared merlin constants used by the prefetch unit and its sub-blocks.
//   PC_INC               : byte increment between sequential instruction words
//   DEFAULT_RESET_VECTOR : default first fetch address after reset
//   INS_W                : instruction word width
package merlin_pfu_pkg;

  localparam int unsigned INS_W = 32;
  localparam int unsigned PC_INC = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/merlin_pfu_if.sv
// Fetch-side bus bundle of merlin_pfu: jump redirect, instruction memory
// request/response port and the decode-stage handshake.
//   master : the prefetch unit side (drives requests and decode outputs)
//   slave  : the environment side (memory, execute and decode stages)
interface merlin_pfu_if #(
  parameter int unsigned P_XLEN = 32
);

  logic              jump_i;
  logic [P_XLEN-1:0] jump_addr_i;
  logic              ireqready_i;
  logic              ireqvalid_o;
  logic [P_XLEN-1:0] ireqaddr_o;
  logic              irspvalid_i;
  logic              irsprerr_i;
  logic [31:0]       irspdata_i;
  logic              ids_dav_o;
  logic              ids_ack_i;
  logic [31:0]       ids_ins_o;
  logic              ids_ferr_o;
  logic [P_XLEN-1:0] ids_pc_o;

  modport master (
    input  jump_i, jump_addr_i, ireqready_i, irspvalid_i, irsprerr_i,
           irspdata_i, ids_ack_i,
    output ireqvalid_o, ireqaddr_o, ids_dav_o, ids_ins_o, ids_ferr_o, ids_pc_o
  );

  modport slave (
    output jump_i, jump_addr_i, ireqready_i, irspvalid_i, irsprerr_i,
           irspdata_i, ids_ack_i,
    input  ireqvalid_o, ireqaddr_o, ids_dav_o, ids_ins_o, ids_ferr_o, ids_pc_o
  );

endinterface

// File: rtl/merlin_fifo.sv
// Synchronous FIFO with flush. flush has priority over push and pop.
// The head entry is read straight from storage, so a push is visible on
// rdata only after the clock edge that writes it.
//   clk_i, reset_i : clock, synchronous active-high reset
//   push, wdata    : write an entry (ignored while full)
//   pop            : drop the head entry (ignored while empty)
//   flush          : empty the FIFO
//   rdata          : head entry
//   empty, full    : occupancy flags
//   count          : number of stored entries
module merlin_fifo #(
  parameter  int unsigned P_WIDTH = 8,
  parameter  int unsigned P_DEPTH = 2,
  localparam int unsigned CNT_W   = $clog2(P_DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [P_WIDTH-1:0] wdata,
  output logic [P_WIDTH-1:0] rdata,
  output logic               empty,
  output logic               full,
  output logic [CNT_W-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(P_DEPTH);

  logic [P_WIDTH-1:0] mem [P_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(P_DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(do_push);
      rd_ptr <= rd_ptr + PTR_W'(do_pop);
      count  <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/merlin_pfu.sv
// Prefetch unit: issues sequential word fetches, buffers in-order responses
// and presents them to the decoder with their PC and fetch-error flag.
// A jump flushes the buffer, redirects fetch and drops every response that
// is still pending for the old stream.
//   clk_i   : clock
//   reset_i : synchronous active-high reset
//   bus     : fetch bundle (jump, memory request/response, decode handshake)
module merlin_pfu
  import merlin_pfu_pkg::*;
#(
  parameter int unsigned       P_XLEN         = 32,
  parameter int unsigned       P_FETCH_DEPTH  = 2,
  parameter logic [P_XLEN-1:0] P_RESET_VECTOR = P_XLEN'(DEFAULT_RESET_VECTOR)
) (
  input  logic        clk_i,
  input  logic        reset_i,
  merlin_pfu_if.master bus
);

  localparam int unsigned CNT_W   = $clog2(P_FETCH_DEPTH + 1);
  localparam int unsigned SUM_W   = CNT_W + 1;
  // Back-to-back jumps can stack stale responses beyond one FIFO's worth.
  localparam int unsigned DISC_W  = CNT_W + 2;
  localparam int unsigned ENTRY_W = INS_W + 1 + P_XLEN;

  logic [P_XLEN-1:0]  req_pc;
  logic [P_XLEN-1:0]  rsp_pc;
  logic [CNT_W-1:0]   outstanding;
  logic [DISC_W-1:0]  discard;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  logic               fifo_full;
  logic [ENTRY_W-1:0] fifo_wdata;
  logic [ENTRY_W-1:0] fifo_rdata;

  logic [P_XLEN-1:0]  jump_tgt;
  logic [P_XLEN-1:0]  reset_pc;
  logic [SUM_W-1:0]   inflight;
  logic               req_valid_c;
  logic               req_fire;
  logic               rsp_live;
  logic               rsp_stale;
  logic               fifo_push;
  logic               fifo_pop;

  assign jump_tgt = bus.jump_addr_i & ~P_XLEN'(3);
  assign reset_pc = P_RESET_VECTOR & ~P_XLEN'(3);

  // Request window: buffered entries plus live in-flight requests.
  assign inflight    = SUM_W'(fifo_count) + SUM_W'(outstanding);
  assign req_valid_c = !bus.jump_i && (inflight < SUM_W'(P_FETCH_DEPTH));
  assign req_fire    = req_valid_c && bus.ireqready_i;

  // Responses belong to the stale stream while discard is non-zero.
  assign rsp_live  = bus.irspvalid_i && (discard == '0);
  assign rsp_stale = bus.irspvalid_i && (discard != '0);
  assign fifo_push = rsp_live && !bus.jump_i;
  assign fifo_pop  = !fifo_empty && bus.ids_ack_i && !bus.jump_i;

  assign fifo_wdata = {bus.irspdata_i, bus.irsprerr_i, rsp_pc};

  merlin_fifo #(
    .P_WIDTH(ENTRY_W),
    .P_DEPTH(P_FETCH_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .flush  (bus.jump_i),
    .wdata  (fifo_wdata),
    .rdata  (fifo_rdata),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .count  (fifo_count)
  );

  assign bus.ireqvalid_o = req_valid_c;
  assign bus.ireqaddr_o  = req_pc;
  assign bus.ids_dav_o   = !fifo_empty;
  assign bus.ids_ins_o   = fifo_rdata[ENTRY_W-1 -: INS_W];
  assign bus.ids_ferr_o  = fifo_rdata[P_XLEN];
  assign bus.ids_pc_o    = fifo_rdata[P_XLEN-1:0];

  // Fetch/response PCs and the live/stale in-flight counters.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      req_pc      <= reset_pc;
      rsp_pc      <= reset_pc;
      outstanding <= '0;
      discard     <= '0;
    end else if (bus.jump_i) begin
      // Everything pending becomes stale; a response this cycle is dropped.
      req_pc      <= jump_tgt;
      rsp_pc      <= jump_tgt;
      outstanding <= '0;
      discard     <= DISC_W'(outstanding) + discard - DISC_W'(bus.irspvalid_i);
    end else begin
      if (req_fire) begin
        req_pc <= req_pc + P_XLEN'(PC_INC);
      end
      if (fifo_push) begin
        rsp_pc <= rsp_pc + P_XLEN'(PC_INC);
      end
      outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_live);
      if (rsp_stale) begin
        discard <= discard - DISC_W'(1);
      end
    end
  end

  // Memory-side and internal protocol checks.
  a_rsp_expected: assert property (@(posedge clk_i) disable iff (reset_i)
    bus.irspvalid_i |-> (outstanding != '0 || discard != '0));

  a_no_push_full: assert property (@(posedge clk_i) disable iff (reset_i)
    fifo_push |-> !fifo_full);

  a_window: assert property (@(posedge clk_i) disable iff (reset_i)
    inflight <= SUM_W'(P_FETCH_DEPTH));

  a_discard_range: assert property (@(posedge clk_i) disable iff (reset_i)
    bus.jump_i |-> (({1'b0, discard} + (DISC_W + 1)'(outstanding)) < (DISC_W + 1)'(2 ** DISC_W)));

endmodule

// File: tb/tb_merlin_pfu.sv
module tb_merlin_pfu;
  import merlin_pfu_pkg::*;

  localparam int unsigned XLEN = 32;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  merlin_pfu_if #(.P_XLEN(XLEN)) bus ();

  merlin_pfu #(
    .P_XLEN        (XLEN),
    .P_FETCH_DEPTH (2),
    .P_RESET_VECTOR(32'h0000_0000)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .bus    (bus)
  );

  int          vectors;
  int          miscompares;
  logic [31:0] mem_q [$];
  logic        mem_hold;
  logic [31:0] err_addr;

  // Instruction memory contents as a function of the word address.
  function automatic logic [31:0] ins_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  // One clock: record the accept of the ending cycle, then present the
  // 1-cycle memory response for the new cycle.
  task automatic cycle();
    logic        acc;
    logic [31:0] a;
    logic        rs;
    #1;
    acc = bus.ireqvalid_o && bus.ireqready_i;
    a   = bus.ireqaddr_o;
    rs  = reset;
    @(posedge clk);
    #1;
    if (rs) mem_q.delete();
    else if (acc === 1'b1) mem_q.push_back(a);
    if (!rs && !mem_hold && mem_q.size() > 0) begin
      a = mem_q.pop_front();
      bus.irspvalid_i = 1'b1;
      bus.irspdata_i  = ins_of(a);
      bus.irsprerr_i  = (a == err_addr);
    end else begin
      bus.irspvalid_i = 1'b0;
      bus.irspdata_i  = '0;
      bus.irsprerr_i  = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    bus.jump_i      = 1'b0;
    bus.jump_addr_i = '0;
    bus.ids_ack_i   = 1'b0;
    bus.ireqready_i = 1'b1;
    mem_hold        = 1'b0;
    err_addr        = 32'hFFFF_FFFF;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (bus.ids_dav_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_dav: got %b expected 0", bus.ids_dav_o);
    end
    #1;
    vectors++;
    if (bus.ireqvalid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_reqvalid: got %b expected 1", bus.ireqvalid_o);
    end
    vectors++;
    if (bus.ireqaddr_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_reqaddr: got %h expected 00000000", bus.ireqaddr_o);
    end
  endtask

  // Sequential stream with ack held high; 0x8 returns a bus error.
  task automatic test_stream();
    logic [31:0] exp_req;
    logic [31:0] exp_pc;
    int          got;
    do_reset();
    bus.ids_ack_i = 1'b1;
    err_addr      = 32'h8;
    exp_req       = 32'h0;
    exp_pc        = 32'h0;
    got           = 0;
    for (int i = 0; i < 40 && got < 6; i++) begin
      #1;
      if (bus.ireqvalid_o === 1'b1) begin
        vectors++;
        if (bus.ireqaddr_o !== exp_req) begin
          miscompares++;
          $display("FAIL stream_reqaddr: got %h expected %h", bus.ireqaddr_o, exp_req);
        end
        exp_req = exp_req + 32'd4;
      end
      if (bus.ids_dav_o === 1'b1) begin
        vectors++;
        if (bus.ids_pc_o !== exp_pc) begin
          miscompares++;
          $display("FAIL stream_pc: got %h expected %h", bus.ids_pc_o, exp_pc);
        end
        vectors++;
        if (bus.ids_ins_o !== ins_of(exp_pc)) begin
          miscompares++;
          $display("FAIL stream_ins: got %h expected %h", bus.ids_ins_o, ins_of(exp_pc));
        end
        vectors++;
        if (bus.ids_ferr_o !== (exp_pc == 32'h8)) begin
          miscompares++;
          $display("FAIL stream_ferr: pc %h got %b expected %b", exp_pc, bus.ids_ferr_o, exp_pc == 32'h8);
        end
        exp_pc = exp_pc + 32'd4;
        got++;
      end
      cycle();
    end
    vectors++;
    if (got != 6) begin
      miscompares++;
      $display("FAIL stream_count: got %0d instructions expected 6 within budget", got);
    end
  endtask

  // Decoder stall: requests stop at two in flight/buffered, then drain in order.
  task automatic test_stall();
    do_reset();
    cycle();
    #1;
    vectors++;
    if (bus.ireqvalid_o !== 1'b1 || bus.ireqaddr_o !== 32'h4) begin
      miscompares++;
      $display("FAIL stall_req2: got valid %b addr %h expected 1 00000004", bus.ireqvalid_o, bus.ireqaddr_o);
    end
    for (int i = 0; i < 4; i++) begin
      cycle();
      #1;
      vectors++;
      if (bus.ireqvalid_o !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_reqvalid: cycle %0d got %b expected 0", i, bus.ireqvalid_o);
      end
      vectors++;
      if (bus.ids_dav_o !== 1'b1 || bus.ids_pc_o !== 32'h0) begin
        miscompares++;
        $display("FAIL stall_head: cycle %0d got dav %b pc %h expected 1 00000000", i, bus.ids_dav_o, bus.ids_pc_o);
      end
    end
    bus.ids_ack_i = 1'b1;
    cycle();
    #1;
    vectors++;
    if (bus.ids_dav_o !== 1'b1 || bus.ids_pc_o !== 32'h4 || bus.ids_ins_o !== ins_of(32'h4)) begin
      miscompares++;
      $display("FAIL stall_drain: got dav %b pc %h ins %h expected 1 00000004 %h", bus.ids_dav_o, bus.ids_pc_o, bus.ids_ins_o, ins_of(32'h4));
    end
    vectors++;
    if (bus.ireqvalid_o !== 1'b1 || bus.ireqaddr_o !== 32'h8) begin
      miscompares++;
      $display("FAIL stall_resume: got valid %b addr %h expected 1 00000008", bus.ireqvalid_o, bus.ireqaddr_o);
    end
    cycle();
    vectors++;
    if (bus.ids_dav_o !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_empty: got dav %b expected 0", bus.ids_dav_o);
    end
  endtask

  // Jump with two requests outstanding: both late responses are dropped.
  task automatic test_jump();
    do_reset();
    mem_hold = 1'b1;
    cycle();
    cycle();
    bus.jump_i      = 1'b1;
    bus.jump_addr_i = 32'h100;
    #1;
    vectors++;
    if (bus.ireqvalid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL jump_noreq: got %b expected 0", bus.ireqvalid_o);
    end
    cycle();
    bus.jump_i = 1'b0;
    mem_hold   = 1'b0;
    #1;
    vectors++;
    if (bus.ireqvalid_o !== 1'b1 || bus.ireqaddr_o !== 32'h100) begin
      miscompares++;
      $display("FAIL jump_firstreq: got valid %b addr %h expected 1 00000100", bus.ireqvalid_o, bus.ireqaddr_o);
    end
    cycle();
    cycle();
    cycle();
    vectors++;
    if (bus.ids_dav_o !== 1'b0) begin
      miscompares++;
      $display("FAIL jump_stale: got dav %b pc %h expected dav 0", bus.ids_dav_o, bus.ids_pc_o);
    end
    cycle();
    vectors++;
    if (bus.ids_dav_o !== 1'b1 || bus.ids_pc_o !== 32'h100 || bus.ids_ins_o !== ins_of(32'h100)) begin
      miscompares++;
      $display("FAIL jump_target: got dav %b pc %h ins %h expected 1 00000100 %h", bus.ids_dav_o, bus.ids_pc_o, bus.ids_ins_o, ins_of(32'h100));
    end
    bus.ids_ack_i = 1'b1;
    cycle();
    vectors++;
    if (bus.ids_dav_o !== 1'b1 || bus.ids_pc_o !== 32'h104) begin
      miscompares++;
      $display("FAIL jump_next: got dav %b pc %h expected 1 00000104", bus.ids_dav_o, bus.ids_pc_o);
    end
  endtask

  // Jump coinciding with a response and an ack on a non-empty FIFO.
  task automatic test_jump_collide();
    do_reset();
    cycle();
    cycle();
    vectors++;
    if (bus.ids_dav_o !== 1'b1 || bus.ids_pc_o !== 32'h0) begin
      miscompares++;
      $display("FAIL collide_pre: got dav %b pc %h expected 1 00000000", bus.ids_dav_o, bus.ids_pc_o);
    end
    bus.jump_i      = 1'b1;
    bus.jump_addr_i = 32'h200;
    bus.ids_ack_i   = 1'b1;
    cycle();
    bus.jump_i = 1'b0;
    vectors++;
    if (bus.ids_dav_o !== 1'b0) begin
      miscompares++;
      $display("FAIL collide_flush: got dav %b pc %h expected dav 0", bus.ids_dav_o, bus.ids_pc_o);
    end
    #1;
    vectors++;
    if (bus.ireqvalid_o !== 1'b1 || bus.ireqaddr_o !== 32'h200) begin
      miscompares++;
      $display("FAIL collide_req: got valid %b addr %h expected 1 00000200", bus.ireqvalid_o, bus.ireqaddr_o);
    end
    cycle();
    cycle();
    vectors++;
    if (bus.ids_dav_o !== 1'b1 || bus.ids_pc_o !== 32'h200 || bus.ids_ins_o !== ins_of(32'h200)) begin
      miscompares++;
      $display("FAIL collide_target: got dav %b pc %h ins %h expected 1 00000200 %h", bus.ids_dav_o, bus.ids_pc_o, bus.ids_ins_o, ins_of(32'h200));
    end
  endtask

  // Address wrap at the top of memory and unaligned jump target.
  task automatic test_wrap();
    do_reset();
    bus.ids_ack_i   = 1'b1;
    bus.jump_i      = 1'b1;
    bus.jump_addr_i = 32'hFFFF_FFFC;
    cycle();
    bus.jump_i = 1'b0;
    #1;
    vectors++;
    if (bus.ireqvalid_o !== 1'b1 || bus.ireqaddr_o !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL wrap_top: got valid %b addr %h expected 1 fffffffc", bus.ireqvalid_o, bus.ireqaddr_o);
    end
    cycle();
    #1;
    vectors++;
    if (bus.ireqvalid_o !== 1'b1 || bus.ireqaddr_o !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_zero: got valid %b addr %h expected 1 00000000", bus.ireqvalid_o, bus.ireqaddr_o);
    end
    cycle();
    vectors++;
    if (bus.ids_dav_o !== 1'b1 || bus.ids_pc_o !== 32'hFFFF_FFFC || bus.ids_ins_o !== ins_of(32'hFFFF_FFFC)) begin
      miscompares++;
      $display("FAIL wrap_head_top: got dav %b pc %h ins %h expected 1 fffffffc %h", bus.ids_dav_o, bus.ids_pc_o, bus.ids_ins_o, ins_of(32'hFFFF_FFFC));
    end
    cycle();
    vectors++;
    if (bus.ids_dav_o !== 1'b1 || bus.ids_pc_o !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_head_zero: got dav %b pc %h expected 1 00000000", bus.ids_dav_o, bus.ids_pc_o);
    end
    bus.jump_i      = 1'b1;
    bus.jump_addr_i = 32'h103;
    cycle();
    bus.jump_i = 1'b0;
    #1;
    vectors++;
    if (bus.ireqvalid_o !== 1'b1 || bus.ireqaddr_o !== 32'h100) begin
      miscompares++;
      $display("FAIL align_req: got valid %b addr %h expected 1 00000100", bus.ireqvalid_o, bus.ireqaddr_o);
    end
    cycle();
    cycle();
    vectors++;
    if (bus.ids_dav_o !== 1'b1 || bus.ids_pc_o !== 32'h100) begin
      miscompares++;
      $display("FAIL align_head: got dav %b pc %h expected 1 00000100", bus.ids_dav_o, bus.ids_pc_o);
    end
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    reset           = 1'b1;
    mem_hold        = 1'b0;
    err_addr        = 32'hFFFF_FFFF;
    bus.jump_i      = 1'b0;
    bus.jump_addr_i = '0;
    bus.ireqready_i = 1'b1;
    bus.irspvalid_i = 1'b0;
    bus.irsprerr_i  = 1'b0;
    bus.irspdata_i  = '0;
    bus.ids_ack_i   = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_jump();
    test_jump_collide();
    test_wrap();
    test_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
